// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount (0..7 units) out of a coin hopper one
// coin at a time, using greedy 5/2/1 denominations limited by per-coin stock.
// The hopper is driven through a 4-phase coin_req/coin_ack handshake. The block
// reports a done pulse with any unpaid shortfall, and latches a sticky fault
// when the hopper fails to acknowledge in time.
module change_dispenser #(
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ch_valid,
  input  logic [2:0]         ch,
  input  logic               restock,
  output logic               coin_req,
  output logic [1:0]         coin_sel,
  input  logic               coin_ack,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [2:0]         owed,
  output logic               fault,
  output logic [STOCK_W-1:0] stock1,
  output logic [STOCK_W-1:0] stock2,
  output logic [STOCK_W-1:0] stock5
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_REQ, ST_RELEASE, ST_DONE, ST_FAULT
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_5    = 2'b11;

  localparam int                 TW    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]      TLAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [STOCK_W-1:0] SINIT = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] SONE  = STOCK_W'(1);

  state_t               state, state_nx;
  logic [2:0]           rem_q;
  logic [1:0]           sel_q;
  logic [1:0]           pick_sel;
  logic [TW-1:0]        tcnt_q;
  logic [STOCK_W-1:0]   stock1_q, stock2_q, stock5_q;
  logic                 short_q;
  logic [2:0]           owed_q;

  // Unit value of a coin code.
  function automatic logic [2:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_1:   return 3'd1;
      SEL_2:   return 3'd2;
      SEL_5:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Greedy choice: largest denomination that fits the remainder and is in stock.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_sel = SEL_NONE;
    if (rem_q >= 3'd5 && stock5_q != '0)      pick_sel = SEL_5;
    else if (rem_q >= 3'd2 && stock2_q != '0) pick_sel = SEL_2;
    else if (rem_q >= 3'd1 && stock1_q != '0) pick_sel = SEL_1;
  end

  // Next-state logic for the payout sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (ch_valid) state_nx = (ch == 3'd0) ? ST_DONE : ST_SELECT;
      ST_SELECT:  state_nx = (pick_sel == SEL_NONE) ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (coin_ack)             state_nx = ST_RELEASE;
        else if (tcnt_q == TLAST) state_nx = ST_FAULT;
      end
      ST_RELEASE: if (!coin_ack) state_nx = (rem_q == 3'd0) ? ST_DONE : ST_SELECT;
      ST_DONE:    state_nx = ST_IDLE;
      ST_FAULT:   state_nx = ST_FAULT;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // State register; reset overrides any handshake in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Datapath: remainder, chosen coin, timeout counter, stock and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q    <= '0;
      sel_q    <= SEL_NONE;
      tcnt_q   <= '0;
      stock1_q <= SINIT;
      stock2_q <= SINIT;
      stock5_q <= SINIT;
      short_q  <= 1'b0;
      owed_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (restock) begin
            stock1_q <= SINIT;
            stock2_q <= SINIT;
            stock5_q <= SINIT;
          end
          if (ch_valid) begin
            rem_q   <= ch;
            short_q <= 1'b0;
            owed_q  <= '0;
          end
        end
        ST_SELECT: begin
          sel_q  <= pick_sel;
          tcnt_q <= '0;
          if (pick_sel == SEL_NONE) begin
            short_q <= 1'b1;
            owed_q  <= rem_q;
          end
        end
        ST_REQ: begin
          if (coin_ack) begin
            rem_q <= rem_q - coin_value(sel_q);
            case (sel_q)
              SEL_1:   stock1_q <= stock1_q - SONE;
              SEL_2:   stock2_q <= stock2_q - SONE;
              SEL_5:   stock5_q <= stock5_q - SONE;
              default: ;
            endcase
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign coin_req = (state == ST_REQ);
  assign coin_sel = (state == ST_REQ || state == ST_RELEASE) ? sel_q : SEL_NONE;
  assign busy     = (state == ST_SELECT || state == ST_REQ || state == ST_RELEASE);
  assign done     = (state == ST_DONE);
  assign fault    = (state == ST_FAULT);
  assign short    = short_q;
  assign owed     = owed_q;
  assign stock1   = stock1_q;
  assign stock2   = stock2_q;
  assign stock5   = stock5_q;

endmodule
